cakegame_uc: RTL and testbench

Control unit for the cake memory game. It drives every control input of the game datapath and consumes its status outputs. It sequences one game: show the 16-step recipe, then accept the player's 16 button plays with a per-play timeout, and end in win or lose. It sits directly beside the datapath inside the game top level and exposes game status and a debug state code.

---
 rtl/cakegame_pkg.sv | 24 ++
 rtl/cakegame_uc_if.sv | 51 +++++
 rtl/cakegame_uc.sv | 122 ++++++++++++
 tb/tb_cakegame_uc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cakegame_pkg.sv
// Shared encodings for the cake memory game control unit: state codes and
// display-select codes.
package cakegame_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        MOSTRA         = 4'h2,
        PROXIMO_MOSTRA = 4'h3,
        FIM_MOSTRA     = 4'h4,
        ESPERA_JOGADA  = 4'h5,
        REGISTRA       = 4'h6,
        COMPARA        = 4'h7,
        PROXIMA_JOGADA = 4'h8,
        ACERTO_FINAL   = 4'h9,
        GANHOU         = 4'hA,
        PERDEU         = 4'hB
    } state_t;

    localparam logic [1:0] SEL_BLANK = 2'd0;
    localparam logic [1:0] SEL_MEM   = 2'd1;
    localparam logic [1:0] SEL_BTN   = 2'd2;

endpackage

// File: rtl/cakegame_uc_if.sv
// Control/status bundle between the game control unit (master) and the
// datapath plus top-level status consumers (slave).
interface cakegame_uc_if;

    logic       iniciar;
    logic       dificuldade_in;
    logic       end_mem_counter;
    logic       correct_play;
    logic       has_play;
    logic       end_show;
    logic       half_show;
    logic       timeout;
    logic [2:0] points;

    logic [1:0] out_sel;
    logic       dificuldade;
    logic       clear_reg;
    logic       enable_reg;
    logic       clear_mem_counter;
    logic       enable_mem_counter;
    logic       clear_show_counter;
    logic       enable_show_counter;
    logic       enable_timeout_counter;
    logic       clear_points_counter;
    logic       enable_points_counter;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, dificuldade_in, end_mem_counter, correct_play,
               has_play, end_show, half_show, timeout, points,
        output out_sel, dificuldade, clear_reg, enable_reg,
               clear_mem_counter, enable_mem_counter, clear_show_counter,
               enable_show_counter, enable_timeout_counter,
               clear_points_counter, enable_points_counter,
               pronto, ganhou, perdeu, db_estado
    );

    modport slave (
        output iniciar, dificuldade_in, end_mem_counter, correct_play,
               has_play, end_show, half_show, timeout, points,
        input  out_sel, dificuldade, clear_reg, enable_reg,
               clear_mem_counter, enable_mem_counter, clear_show_counter,
               enable_show_counter, enable_timeout_counter,
               clear_points_counter, enable_points_counter,
               pronto, ganhou, perdeu, db_estado
    );

endinterface

// File: rtl/cakegame_uc.sv
// Cake memory game control unit: shows the 16-step recipe, then checks the
// player's 16 plays with a per-play timeout, ending in win or lose.
module cakegame_uc
    import cakegame_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    cakegame_uc_if.master bus
);

    state_t state;
    state_t next_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= INICIAL;
        else          state <= next_state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 bus.dificuldade <= 1'b0;
        else if (state == PREPARACAO) bus.dificuldade <= bus.dificuldade_in;
    end

    always_comb begin
        next_state = INICIAL;
        case (state)
            INICIAL:        next_state = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     next_state = MOSTRA;
            MOSTRA: begin
                if (!bus.end_show)            next_state = MOSTRA;
                else if (bus.end_mem_counter) next_state = FIM_MOSTRA;
                else                          next_state = PROXIMO_MOSTRA;
            end
            PROXIMO_MOSTRA: next_state = MOSTRA;
            FIM_MOSTRA:     next_state = ESPERA_JOGADA;
            // Timeout beats a simultaneous play.
            ESPERA_JOGADA: begin
                if (bus.timeout)       next_state = PERDEU;
                else if (bus.has_play) next_state = REGISTRA;
                else                   next_state = ESPERA_JOGADA;
            end
            REGISTRA:       next_state = COMPARA;
            COMPARA: begin
                if (!bus.correct_play)        next_state = PERDEU;
                else if (bus.end_mem_counter) next_state = ACERTO_FINAL;
                else                          next_state = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: next_state = ESPERA_JOGADA;
            ACERTO_FINAL:   next_state = GANHOU;
            GANHOU:         next_state = bus.iniciar ? PREPARACAO : GANHOU;
            PERDEU:         next_state = bus.iniciar ? PREPARACAO : PERDEU;
            default:        next_state = INICIAL;
        endcase
    end

    assign bus.db_estado = state;

    always_comb begin
        bus.out_sel                = SEL_BLANK;
        bus.clear_reg              = 1'b0;
        bus.enable_reg             = 1'b0;
        bus.clear_mem_counter      = 1'b0;
        bus.enable_mem_counter     = 1'b0;
        bus.clear_show_counter     = 1'b0;
        bus.enable_show_counter    = 1'b0;
        bus.enable_timeout_counter = 1'b0;
        bus.clear_points_counter   = 1'b0;
        bus.enable_points_counter  = 1'b0;
        bus.pronto                 = 1'b0;
        bus.ganhou                 = 1'b0;
        bus.perdeu                 = 1'b0;
        case (state)
            PREPARACAO: begin
                bus.clear_reg            = 1'b1;
                bus.clear_mem_counter    = 1'b1;
                bus.clear_show_counter   = 1'b1;
                bus.clear_points_counter = 1'b1;
            end
            // Blank the second half of each item so repeats are visible.
            MOSTRA: begin
                bus.enable_show_counter = 1'b1;
                bus.out_sel             = bus.half_show ? SEL_BLANK : SEL_MEM;
            end
            PROXIMO_MOSTRA: begin
                bus.enable_mem_counter = 1'b1;
                bus.clear_show_counter = 1'b1;
            end
            FIM_MOSTRA: begin
                bus.clear_mem_counter = 1'b1;
                bus.clear_reg         = 1'b1;
            end
            ESPERA_JOGADA: begin
                bus.out_sel                = SEL_BTN;
                bus.enable_timeout_counter = 1'b1;
            end
            REGISTRA: begin
                bus.out_sel    = SEL_BTN;
                bus.enable_reg = 1'b1;
            end
            COMPARA:        bus.out_sel = SEL_BTN;
            PROXIMA_JOGADA: begin
                bus.enable_mem_counter    = 1'b1;
                bus.enable_points_counter = (bus.points != 3'd7);
            end
            ACERTO_FINAL:   bus.enable_points_counter = (bus.points != 3'd7);
            GANHOU: begin
                bus.pronto = 1'b1;
                bus.ganhou = 1'b1;
            end
            PERDEU: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
            end
            default: begin
                bus.clear_reg          = 1'b1;
                bus.clear_mem_counter  = 1'b1;
                bus.clear_show_counter = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cakegame_uc.sv
// Self-checking bench for cakegame_uc: vector table, directed game sequences
// and a randomized run against a rule-level reference model.
module tb_cakegame_uc;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    cakegame_uc_if bus();

    cakegame_uc dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_cnt  = 0;
    bit count_en = 1'b0;
    bit er_seen  = 1'b0;

    logic [14:0] dut_out;
    assign dut_out = {bus.out_sel, bus.dificuldade, bus.clear_reg, bus.enable_reg,
                      bus.clear_mem_counter, bus.enable_mem_counter,
                      bus.clear_show_counter, bus.enable_show_counter,
                      bus.enable_timeout_counter, bus.clear_points_counter,
                      bus.enable_points_counter, bus.pronto, bus.ganhou, bus.perdeu};

    typedef struct {
        bit       ini, din, half, eshow, emem, hplay, corr, tmo;
        bit [2:0] pts;
        int       est, esel;
        bit       eem, eep;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        if (count_en && bus.enable_mem_counter) mem_cnt++;
        if (bus.enable_reg) er_seen = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iniciar = 0; bus.dificuldade_in = 0; bus.end_mem_counter = 0;
        bus.correct_play = 0; bus.has_play = 0; bus.end_show = 0;
        bus.half_show = 0; bus.timeout = 0; bus.points = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Reference: expected outputs for a game phase, written from the state descriptions.
    function automatic logic [14:0] model_out(int st, bit half, logic [2:0] pts, bit dif);
        logic [1:0] sel = 2'd0;
        bit cr = 0, er = 0, cm = 0, em = 0, cs = 0, es = 0, et = 0;
        bit cp = 0, ep = 0, pr = 0, g = 0, p = 0;
        case (st)
            1:  begin cr = 1; cm = 1; cs = 1; cp = 1; end
            2:  begin es = 1; sel = half ? 2'd0 : 2'd1; end
            3:  begin em = 1; cs = 1; end
            4:  begin cm = 1; cr = 1; end
            5:  begin sel = 2'd2; et = 1; end
            6:  begin sel = 2'd2; er = 1; end
            7:  sel = 2'd2;
            8:  begin em = 1; ep = (pts != 3'd7); end
            9:  ep = (pts != 3'd7);
            10: begin pr = 1; g = 1; end
            11: begin pr = 1; p = 1; end
            default: begin cr = 1; cm = 1; cs = 1; end
        endcase
        return {sel, dif, cr, er, cm, em, cs, es, et, cp, ep, pr, g, p};
    endfunction

    function automatic int model_next(int st, bit ini, bit eshow, bit emem,
                                      bit hplay, bit corr, bit tmo);
        case (st)
            0:       return ini ? 1 : 0;
            1:       return 2;
            2:       return !eshow ? 2 : (emem ? 4 : 3);
            3:       return 2;
            4:       return 5;
            5:       return tmo ? 11 : (hplay ? 6 : 5);
            6:       return 7;
            7:       return !corr ? 11 : (emem ? 9 : 8);
            8:       return 5;
            9:       return 10;
            10, 11:  return ini ? 1 : st;
            default: return 0;
        endcase
    endfunction

    task automatic go_espera();
        bus.iniciar = 1; bus.dificuldade_in = 1;
        step();
        bus.iniciar = 0;
        step();
        bus.end_show = 1; bus.end_mem_counter = 1;
        step();
        bus.end_show = 0; bus.end_mem_counter = 0;
        step();
    endtask

    vec_t tbl[20];

    initial begin
        int mst;
        bit mdif;
        bit [2:0] pts;
        int nxt;

        tbl[0]  = '{0,1,0,0,0,0,0,0,3'd0,  0, 0, 0, 0};
        tbl[1]  = '{1,1,0,0,0,0,0,0,3'd0,  0, 0, 0, 0};
        tbl[2]  = '{0,1,0,0,0,0,0,0,3'd0,  1, 0, 0, 0};
        tbl[3]  = '{0,1,0,0,0,0,0,0,3'd0,  2, 1, 0, 0};
        tbl[4]  = '{0,1,1,0,0,0,0,0,3'd0,  2, 0, 0, 0};
        tbl[5]  = '{0,1,1,1,0,0,0,0,3'd0,  2, 0, 0, 0};
        tbl[6]  = '{0,1,0,0,0,0,0,0,3'd0,  3, 0, 1, 0};
        tbl[7]  = '{0,1,0,1,1,0,0,0,3'd0,  2, 1, 0, 0};
        tbl[8]  = '{0,1,0,0,0,0,0,0,3'd0,  4, 0, 0, 0};
        tbl[9]  = '{0,1,0,0,0,0,0,0,3'd0,  5, 2, 0, 0};
        tbl[10] = '{0,1,0,0,0,1,0,0,3'd0,  5, 2, 0, 0};
        tbl[11] = '{0,1,0,0,0,0,0,0,3'd0,  6, 2, 0, 0};
        tbl[12] = '{0,1,0,0,0,0,1,0,3'd0,  7, 2, 0, 0};
        tbl[13] = '{0,1,0,0,0,0,0,0,3'd7,  8, 0, 1, 0};
        tbl[14] = '{0,1,0,0,0,1,0,0,3'd0,  5, 2, 0, 0};
        tbl[15] = '{0,1,0,0,0,0,0,0,3'd0,  6, 2, 0, 0};
        tbl[16] = '{0,1,0,0,0,0,0,0,3'd0,  7, 2, 0, 0};
        tbl[17] = '{0,1,0,0,0,0,0,0,3'd0, 11, 0, 0, 0};
        tbl[18] = '{1,1,0,0,0,0,0,0,3'd0, 11, 0, 0, 0};
        tbl[19] = '{0,1,0,0,0,0,0,0,3'd0,  1, 0, 0, 0};

        // Vector table from reset.
        do_reset();
        chk("reset_state", bus.db_estado, 0);
        chk("reset_outputs", dut_out, model_out(0, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            bus.iniciar = tbl[i].ini; bus.dificuldade_in = tbl[i].din;
            bus.half_show = tbl[i].half; bus.end_show = tbl[i].eshow;
            bus.end_mem_counter = tbl[i].emem; bus.has_play = tbl[i].hplay;
            bus.correct_play = tbl[i].corr; bus.timeout = tbl[i].tmo;
            bus.points = tbl[i].pts;
            #1;
            chk($sformatf("vec%0d_state", i), bus.db_estado, tbl[i].est);
            chk($sformatf("vec%0d_out_sel", i), bus.out_sel, tbl[i].esel);
            chk($sformatf("vec%0d_en_mem", i), bus.enable_mem_counter, tbl[i].eem);
            chk($sformatf("vec%0d_en_points", i), bus.enable_points_counter, tbl[i].eep);
            step();
        end
        chk("vec_dificuldade_latched", bus.dificuldade, 1);

        // Asynchronous reset in the middle of MOSTRA.
        do_reset();
        bus.iniciar = 1; bus.dificuldade_in = 1;
        step();
        bus.iniciar = 0;
        step();
        step();
        chk("pre_async_state", bus.db_estado, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_state", bus.db_estado, 0);
        chk("async_clear_mem", bus.clear_mem_counter, 1);
        chk("async_out_sel", bus.out_sel, 0);
        chk("async_pronto", bus.pronto, 0);
        chk("async_dificuldade", bus.dificuldade, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Full correct game: 16 shown items, 16 correct plays.
        do_reset();
        bus.iniciar = 1;
        step();
        bus.iniciar = 0;
        chk("start_prep_state", bus.db_estado, 1);
        chk("start_clear_points", bus.clear_points_counter, 1);
        step();
        for (int item = 0; item < 16; item++) begin
            bus.half_show = 0;
            #1;
            chk($sformatf("show%0d_first_half", item), bus.out_sel, 1);
            step();
            bus.half_show = 1; bus.end_show = 1; bus.end_mem_counter = (item == 15);
            #1;
            chk($sformatf("show%0d_second_half", item), bus.out_sel, 0);
            step();
            bus.end_show = 0; bus.end_mem_counter = 0; bus.half_show = 0;
            if (item < 15) begin
                chk($sformatf("show%0d_next", item), bus.db_estado, 3);
                step();
            end
        end
        chk("fim_mostra_state", bus.db_estado, 4);
        step();
        chk("espera_state", bus.db_estado, 5);
        chk("espera_out_sel", bus.out_sel, 2);
        mem_cnt = 0;
        count_en = 1'b1;
        for (int p = 0; p < 16; p++) begin
            pts = (p < 7) ? 3'(p) : 3'd7;
            bus.points = pts;
            bus.has_play = 0;
            #1;
            chk($sformatf("play%0d_timeout_en", p), bus.enable_timeout_counter, 1);
            step();
            bus.has_play = 1;
            step();
            bus.has_play = 0;
            chk($sformatf("play%0d_registra", p), bus.enable_reg, 1);
            step();
            bus.correct_play = 1; bus.end_mem_counter = (p == 15);
            #1;
            chk($sformatf("play%0d_compara", p), bus.db_estado, 7);
            step();
            bus.correct_play = 0; bus.end_mem_counter = 0;
            chk($sformatf("play%0d_after_ok", p), bus.db_estado, (p < 15) ? 8 : 9);
            chk($sformatf("play%0d_en_points", p), bus.enable_points_counter, (pts != 3'd7) ? 1 : 0);
            step();
        end
        count_en = 1'b0;
        chk("game_mem_pulses", mem_cnt, 15);
        chk("game_won_state", bus.db_estado, 10);
        chk("game_ganhou", bus.ganhou, 1);
        chk("game_pronto", bus.pronto, 1);
        chk("game_perdeu", bus.perdeu, 0);
        bus.iniciar = 1;
        step();
        chk("restart_held_prep", bus.db_estado, 1);
        step();
        step();
        chk("restart_held_ignored", bus.db_estado, 2);
        bus.iniciar = 0;

        // Timeout together with a play, then restart with a new difficulty.
        do_reset();
        go_espera();
        chk("tmo_pre_state", bus.db_estado, 5);
        chk("tmo_dif_latched", bus.dificuldade, 1);
        er_seen = 1'b0;
        bus.timeout = 1; bus.has_play = 1;
        step();
        bus.timeout = 0; bus.has_play = 0;
        step();
        chk("tmo_state", bus.db_estado, 11);
        chk("tmo_perdeu", bus.perdeu, 1);
        chk("tmo_no_enable_reg", er_seen, 0);
        bus.dificuldade_in = 0; bus.iniciar = 1;
        step();
        bus.iniciar = 0;
        chk("relaunch_prep", bus.db_estado, 1);
        step();
        chk("relaunch_dificuldade", bus.dificuldade, 0);

        // Randomized run against the reference model.
        do_reset();
        mst = 0;
        mdif = 0;
        for (int i = 0; i < 2000; i++) begin
            bus.iniciar = ($urandom_range(3) == 0);
            bus.dificuldade_in = $urandom_range(1);
            bus.half_show = $urandom_range(1);
            bus.end_show = ($urandom_range(3) == 0);
            bus.end_mem_counter = ($urandom_range(3) == 0);
            bus.has_play = ($urandom_range(2) == 0);
            bus.correct_play = ($urandom_range(3) != 0);
            bus.timeout = ($urandom_range(7) == 0);
            bus.points = 3'($urandom_range(7));
            #1;
            chk($sformatf("rand%0d_outputs", i), dut_out,
                model_out(mst, bus.half_show, bus.points, mdif));
            chk($sformatf("rand%0d_state", i), bus.db_estado, mst);
            nxt = model_next(mst, bus.iniciar, bus.end_show, bus.end_mem_counter,
                             bus.has_play, bus.correct_play, bus.timeout);
            if (mst == 1) mdif = bus.dificuldade_in;
            mst = nxt;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
